// File: rtl/alu_wb_stage_if.sv
// Bundle of the ALU-result, writeback, branch-resolve and forwarding signals of alu_wb_stage.
// Latency: none (wires only).
// Backpressure: in_ready/wb_ready carried as plain signals; master = environment, slave = stage.
// Ports (master view):
//   out: in_valid in_opcode in_result in_rd in_wb_en in_target flush wb_ready fwd_addr
//   in : in_ready wb_valid wb_addr wb_data br_taken br_target fwd_hit fwd_data
interface alu_wb_stage_if #(
   parameter int WORD_W  = 16,
   parameter int OPC_W   = 4,
   parameter int RADDR_W = 4,
   parameter int PC_W    = 16
);
   logic               in_valid;
   logic               in_ready;
   logic [OPC_W-1:0]   in_opcode;
   logic [WORD_W-1:0]  in_result;
   logic [RADDR_W-1:0] in_rd;
   logic               in_wb_en;
   logic [PC_W-1:0]    in_target;
   logic               flush;
   logic               wb_valid;
   logic               wb_ready;
   logic [RADDR_W-1:0] wb_addr;
   logic [WORD_W-1:0]  wb_data;
   logic               br_taken;
   logic [PC_W-1:0]    br_target;
   logic [RADDR_W-1:0] fwd_addr;
   logic               fwd_hit;
   logic [WORD_W-1:0]  fwd_data;

   modport master (
      output in_valid, in_opcode, in_result, in_rd, in_wb_en, in_target, flush, wb_ready, fwd_addr,
      input  in_ready, wb_valid, wb_addr, wb_data, br_taken, br_target, fwd_hit, fwd_data
   );

   modport slave (
      input  in_valid, in_opcode, in_result, in_rd, in_wb_en, in_target, flush, wb_ready, fwd_addr,
      output in_ready, wb_valid, wb_addr, wb_data, br_taken, br_target, fwd_hit, fwd_data
   );
endinterface

// File: rtl/alu_wb_stage.sv
// ALU writeback stage: 2-entry writeback FIFO, branch resolve pulse, combinational forwarding lookup.
// Latency: accepted result visible on wb_* one cycle later; br_taken one cycle after branch accept.
// Backpressure: in_ready drops when both entries are occupied or flush is high; head held until wb_ready.
// Ports: clk, rst_n (async active-low); bus (alu_wb_stage_if.slave) carrying the ALU input,
//   register-file write port, branch outcome and forwarding lookup.
module alu_wb_stage #(
   parameter int WORD_W  = 16,
   parameter int OPC_W   = 4,
   parameter int RADDR_W = 4,
   parameter int PC_W    = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   alu_wb_stage_if.slave  bus
);
   localparam logic [OPC_W-1:0] ALU_NOP  = OPC_W'(0);
   localparam logic [OPC_W-1:0] ALU_BEZ  = OPC_W'(8);
   localparam logic [OPC_W-1:0] ALU_BNEZ = OPC_W'(9);
   localparam logic [OPC_W-1:0] ALU_BEQ  = OPC_W'(10);

   logic [1:0]         count;
   logic               wr_ptr;
   logic               rd_ptr;
   logic [RADDR_W-1:0] ent_rd  [2];
   logic [WORD_W-1:0]  ent_dat [2];
   logic [RADDR_W-1:0] last_addr;
   logic [WORD_W-1:0]  last_data;
   logic               br_taken_q;
   logic [PC_W-1:0]    br_target_q;

   logic in_ready;
   logic accept;
   logic is_branch;
   logic push;
   logic pop;
   logic wb_valid;
   logic young;

   assign in_ready  = (count != 2'd2) & ~bus.flush;
   assign accept    = bus.in_valid & in_ready;
   assign is_branch = (bus.in_opcode == ALU_BEZ) | (bus.in_opcode == ALU_BNEZ) |
                      (bus.in_opcode == ALU_BEQ);
   assign push      = accept & ~is_branch & (bus.in_opcode != ALU_NOP) & bus.in_wb_en;
   assign wb_valid  = (count != 2'd0);
   assign pop       = wb_valid & bus.wb_ready;
   // Most recently written slot; equals rd_ptr when only one entry is held.
   assign young     = ~wr_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count      <= 2'd0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         ent_rd[0]  <= '0;
         ent_rd[1]  <= '0;
         ent_dat[0] <= '0;
         ent_dat[1] <= '0;
         last_addr  <= '0;
         last_data  <= '0;
      end else if (bus.flush) begin
         // in_ready is low during flush, so no push can coincide; pop is suppressed too.
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (push) begin
            ent_rd[wr_ptr]  <= bus.in_rd;
            ent_dat[wr_ptr] <= bus.in_result;
            wr_ptr          <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr    <= ~rd_ptr;
            last_addr <= ent_rd[rd_ptr];
            last_data <= ent_dat[rd_ptr];
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_taken_q  <= 1'b0;
         br_target_q <= '0;
      end else begin
         br_taken_q <= accept & is_branch & bus.in_result[0];
         if (accept & is_branch & bus.in_result[0]) begin
            br_target_q <= bus.in_target;
         end
      end
   end

   // Youngest matching entry wins; an entry popped this cycle is still valid here.
   always_comb begin
      bus.fwd_hit  = 1'b0;
      bus.fwd_data = '0;
      if (wb_valid && (ent_rd[young] == bus.fwd_addr)) begin
         bus.fwd_hit  = 1'b1;
         bus.fwd_data = ent_dat[young];
      end else if ((count == 2'd2) && (ent_rd[rd_ptr] == bus.fwd_addr)) begin
         bus.fwd_hit  = 1'b1;
         bus.fwd_data = ent_dat[rd_ptr];
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.wb_valid  = wb_valid;
   // When empty, present the last popped head instead of a stale slot.
   assign bus.wb_addr   = wb_valid ? ent_rd[rd_ptr]  : last_addr;
   assign bus.wb_data   = wb_valid ? ent_dat[rd_ptr] : last_data;
   assign bus.br_taken  = br_taken_q;
   assign bus.br_target = br_target_q;
endmodule
